// File: rtl/dm_sized.sv
// Byte-addressable data memory for the MEM stage: sized stores with lane enables,
// extended sub-word loads on a registered read port, and misaligned-access capture.
module dm_sized #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        rd_valid,
    output logic        misaligned,
    output logic [31:0] fault_addr
);

    localparam int unsigned IdxWidth = ADDR_WIDTH - 2;
    localparam int unsigned Depth    = 1 << IdxWidth;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10,
        SzRsvd = 2'b11
    } size_e;

    logic [31:0] mem [Depth];

    logic [IdxWidth-1:0] word_idx;
    logic [1:0]          lane;
    logic                is_byte;
    logic                is_half;
    logic                is_word;
    logic                aligned;
    logic                access;
    logic                do_write;
    logic [3:0]          byte_en;
    logic [31:0]         wr_data;
    logic [31:0]         rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         load_data;

    assign word_idx = address[ADDR_WIDTH-1:2];
    assign lane     = address[1:0];

    // Reserved size decodes as a word access.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        unique case (size_e'(mem_size))
            SzByte:         is_byte = 1'b1;
            SzHalf:         is_half = 1'b1;
            SzWord, SzRsvd: is_word = 1'b1;
            default:        is_word = 1'b1;
        endcase
    end

    assign aligned  = is_byte | (is_half & ~lane[0]) | (is_word & (lane == 2'b00));
    assign access   = mem_read | mem_write;
    assign do_write = mem_write & aligned;

    always_comb begin
        byte_en = 4'b0000;
        wr_data = data_in;
        if (is_byte) begin
            byte_en       = 4'b0000;
            byte_en[lane] = 1'b1;
            wr_data       = {4{data_in[7:0]}};
        end else if (is_half) begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{data_in[15:0]}};
        end else begin
            byte_en = 4'b1111;
            wr_data = data_in;
        end
    end

    // Array has no reset; contents survive reset assertion.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (do_write && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Combinational read of the old word gives read-before-write on a shared cycle.
    assign rd_word = mem[word_idx];

    always_comb begin
        rd_byte = 8'h00;
        unique case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        if (is_byte) begin
            load_data = {{24{rd_byte[7] & ~mem_unsigned}}, rd_byte};
        end else if (is_half) begin
            load_data = {{16{rd_half[15] & ~mem_unsigned}}, rd_half};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= 32'h0;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
            fault_addr <= 32'h0;
        end else begin
            rd_valid <= mem_read;
            if (mem_read) begin
                data_out <= aligned ? load_data : 32'h0;
            end
            if (access && !aligned) begin
                misaligned <= 1'b1;
                // First fault wins; later faults leave the captured address alone.
                if (!misaligned) begin
                    fault_addr <= address;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_sized.sv
// Directed self-checking bench for dm_sized with hand-computed expected values.
module tb_dm_sized;

    logic        clock;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        misaligned;
    logic [31:0] fault_addr;

    int nvec;
    int nerr;

    dm_sized #(.ADDR_WIDTH(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .misaligned   (misaligned),
        .fault_addr   (fault_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One access through one rising edge; outputs sampled 1 time unit later.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] d);
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = un;
        address      = a;
        data_in      = d;
        @(posedge clock);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        nvec++;
        if (data_out !== 32'h0) begin
            nerr++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 32'h0);
        end
        nvec++;
        if (rd_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid);
        end
        nvec++;
        if (misaligned !== 1'b0) begin
            nerr++; $display("FAIL reset_misaligned got=%b exp=0", misaligned);
        end
        nvec++;
        if (fault_addr !== 32'h0) begin
            nerr++; $display("FAIL reset_fault_addr got=%h exp=%h", fault_addr, 32'h0);
        end
    endtask

    task automatic test_word();
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
        nvec++;
        if (rd_valid !== 1'b0) begin
            nerr++; $display("FAIL store_no_valid got=%b exp=0", rd_valid);
        end
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        nvec++;
        if (data_out !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL word_load got=%h exp=%h", data_out, 32'hDEADBEEF);
        end
        nvec++;
        if (rd_valid !== 1'b1) begin
            nerr++; $display("FAIL word_load_valid got=%b exp=1", rd_valid);
        end
        @(posedge clock);
        #1;
        nvec++;
        if (rd_valid !== 1'b0) begin
            nerr++; $display("FAIL valid_pulse got=%b exp=0", rd_valid);
        end
        nvec++;
        if (data_out !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL data_hold got=%h exp=%h", data_out, 32'hDEADBEEF);
        end
    endtask

    task automatic test_byte();
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h020, 32'h00000000);
        op(1'b0, 1'b1, 2'b00, 1'b0, 32'h021, 32'hFFFFFF80);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
        nvec++;
        if (data_out !== 32'h00008000) begin
            nerr++; $display("FAIL sb_word got=%h exp=%h", data_out, 32'h00008000);
        end
        op(1'b1, 1'b0, 2'b00, 1'b0, 32'h021, 32'h0);
        nvec++;
        if (data_out !== 32'hFFFFFF80) begin
            nerr++; $display("FAIL lb got=%h exp=%h", data_out, 32'hFFFFFF80);
        end
        op(1'b1, 1'b0, 2'b00, 1'b1, 32'h021, 32'h0);
        nvec++;
        if (data_out !== 32'h00000080) begin
            nerr++; $display("FAIL lbu got=%h exp=%h", data_out, 32'h00000080);
        end
        op(1'b1, 1'b0, 2'b00, 1'b0, 32'h022, 32'h0);
        nvec++;
        if (data_out !== 32'h00000000) begin
            nerr++; $display("FAIL lb_untouched got=%h exp=%h", data_out, 32'h0);
        end
    endtask

    task automatic test_half();
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h030, 32'h11111111);
        op(1'b0, 1'b1, 2'b01, 1'b0, 32'h032, 32'hABCD9234);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h030, 32'h0);
        nvec++;
        if (data_out !== 32'h92341111) begin
            nerr++; $display("FAIL sh_word got=%h exp=%h", data_out, 32'h92341111);
        end
        op(1'b1, 1'b0, 2'b01, 1'b0, 32'h032, 32'h0);
        nvec++;
        if (data_out !== 32'hFFFF9234) begin
            nerr++; $display("FAIL lh got=%h exp=%h", data_out, 32'hFFFF9234);
        end
        op(1'b1, 1'b0, 2'b01, 1'b1, 32'h032, 32'h0);
        nvec++;
        if (data_out !== 32'h00009234) begin
            nerr++; $display("FAIL lhu got=%h exp=%h", data_out, 32'h00009234);
        end
        op(1'b1, 1'b0, 2'b01, 1'b0, 32'h030, 32'h0);
        nvec++;
        if (data_out !== 32'h00001111) begin
            nerr++; $display("FAIL lh_low got=%h exp=%h", data_out, 32'h00001111);
        end
    endtask

    task automatic test_reserved();
        op(1'b0, 1'b1, 2'b11, 1'b0, 32'h060, 32'h89ABCDEF);
        op(1'b1, 1'b0, 2'b11, 1'b0, 32'h060, 32'h0);
        nvec++;
        if (data_out !== 32'h89ABCDEF) begin
            nerr++; $display("FAIL rsvd_word got=%h exp=%h", data_out, 32'h89ABCDEF);
        end
        nvec++;
        if (misaligned !== 1'b0) begin
            nerr++; $display("FAIL rsvd_aligned got=%b exp=0", misaligned);
        end
    endtask

    task automatic test_misalign();
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h040, 32'hCAFEF00D);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h041, 32'h0);
        nvec++;
        if (data_out !== 32'h0) begin
            nerr++; $display("FAIL mis_data got=%h exp=%h", data_out, 32'h0);
        end
        nvec++;
        if (rd_valid !== 1'b1) begin
            nerr++; $display("FAIL mis_valid got=%b exp=1", rd_valid);
        end
        nvec++;
        if (misaligned !== 1'b1) begin
            nerr++; $display("FAIL mis_flag got=%b exp=1", misaligned);
        end
        nvec++;
        if (fault_addr !== 32'h041) begin
            nerr++; $display("FAIL mis_addr got=%h exp=%h", fault_addr, 32'h041);
        end
        op(1'b0, 1'b1, 2'b01, 1'b0, 32'h043, 32'h0000FFFF);
        op(1'b0, 1'b1, 2'b11, 1'b0, 32'h042, 32'h00000000);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h040, 32'h0);
        nvec++;
        if (data_out !== 32'hCAFEF00D) begin
            nerr++; $display("FAIL mis_no_write got=%h exp=%h", data_out, 32'hCAFEF00D);
        end
        nvec++;
        if (fault_addr !== 32'h041) begin
            nerr++; $display("FAIL first_fault got=%h exp=%h", fault_addr, 32'h041);
        end
        nvec++;
        if (misaligned !== 1'b1) begin
            nerr++; $display("FAIL mis_sticky got=%b exp=1", misaligned);
        end
    endtask

    task automatic test_back_to_back();
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h050, 32'hAAAAAAAA);
        op(1'b1, 1'b1, 2'b10, 1'b0, 32'h050, 32'h55555555);
        nvec++;
        if (data_out !== 32'hAAAAAAAA) begin
            nerr++; $display("FAIL rbw_old got=%h exp=%h", data_out, 32'hAAAAAAAA);
        end
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h050, 32'h0);
        nvec++;
        if (data_out !== 32'h55555555) begin
            nerr++; $display("FAIL rbw_new got=%h exp=%h", data_out, 32'h55555555);
        end
        nvec++;
        if (rd_valid !== 1'b1) begin
            nerr++; $display("FAIL b2b_valid got=%b exp=1", rd_valid);
        end
    endtask

    task automatic test_reset_wrap();
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        nvec++;
        if (data_out !== 32'h0 || rd_valid !== 1'b0) begin
            nerr++; $display("FAIL async_reset data=%h valid=%b exp=0/0", data_out, rd_valid);
        end
        nvec++;
        if (misaligned !== 1'b0 || fault_addr !== 32'h0) begin
            nerr++; $display("FAIL async_reset_status mis=%b addr=%h exp=0/0",
                             misaligned, fault_addr);
        end
        // A load sampled while reset is held must not produce a valid result.
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        nvec++;
        if (rd_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_discard got=%b exp=0", rd_valid);
        end
        reset = 1'b0;
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h1004, 32'h12345678);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0004, 32'h0);
        nvec++;
        if (data_out !== 32'h12345678) begin
            nerr++; $display("FAIL wrap got=%h exp=%h", data_out, 32'h12345678);
        end
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        nvec++;
        if (data_out !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL array_survives got=%h exp=%h", data_out, 32'hDEADBEEF);
        end
    endtask

    initial begin
        nvec         = 0;
        nerr         = 0;
        reset        = 1'b1;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 2'b10;
        mem_unsigned = 1'b0;
        address      = 32'h0;
        data_in      = 32'h0;
        #1;
        test_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        test_word();
        test_byte();
        test_half();
        test_reserved();
        test_misalign();
        test_back_to_back();
        test_reset_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
